// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// requester identifiers and the default access latency.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LDR = 1'b1;

  localparam int DEFAULT_WAIT_CYCLES = 1;

endpackage : arb_pkg

// File: rtl/rr_pick2.sv
// Two-input round-robin selector: a lone eligible requester wins, a tie goes
// to the requester that did not win last time.
module rr_pick2
  import arb_pkg::*;
(
  input  logic elig_cpu,
  input  logic elig_ldr,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave it unassigned and infer a latch.
  always_comb begin
    grant_valid = elig_cpu | elig_ldr;
    grant_id    = GNT_CPU;
    if (elig_cpu && elig_ldr) begin
      grant_id = ~last_grant;
    end else if (elig_ldr) begin
      grant_id = GNT_LDR;
    end
  end

endmodule : rr_pick2

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the SCPU data port and the
// loader/debug master, one transaction at a time with a fixed access latency.
module dm_arbiter
  import arb_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,

  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  input  logic          ldr_lock,

  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
  input  logic [DW-1:0] dm_rdata,
  output logic          busy
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic            last_grant_q;
  logic            grant_q;
  logic            lat_we_q;
  logic [AW-1:0]   lat_addr_q;
  logic [DW-1:0]   lat_wdata_q;

  logic            grant_valid;
  logic            grant_id;

  // Lock only removes the CPU from arbitration; the round-robin pointer moves
  // solely on actual grants.
  rr_pick2 u_pick (
    .elig_cpu    (cpu_req & ~ldr_lock),
    .elig_ldr    (ldr_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dm_we     = 1'b0;
    cpu_ready = 1'b0;
    ldr_ack   = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant_valid) state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          dm_we   = lat_we_q;
          state_d = RESP;
        end
      end
      RESP: begin
        cpu_ready = (grant_q == GNT_CPU);
        ldr_ack   = (grant_q == GNT_LDR);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: only control and datapath registers are reset; DM contents live
  // outside this block and are never cleared here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      last_grant_q <= GNT_LDR;
      grant_q      <= GNT_CPU;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      cpu_rdata    <= '0;
      ldr_rdata    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            last_grant_q <= grant_id;
            grant_q      <= grant_id;
            cnt_q        <= CNT_INIT;
            if (grant_id == GNT_CPU) begin
              lat_we_q    <= cpu_we;
              lat_addr_q  <= cpu_addr;
              lat_wdata_q <= cpu_wdata;
            end else begin
              lat_we_q    <= ldr_we;
              lat_addr_q  <= ldr_addr;
              lat_wdata_q <= ldr_wdata;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!lat_we_q) begin
              if (grant_q == GNT_CPU) cpu_rdata <= dm_rdata;
              else                    ldr_rdata <= dm_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The DM bus always reflects the latched transaction, so it holds through
  // RESP and idle periods without depending on live request inputs.
  assign dm_addr  = lat_addr_q;
  assign dm_wdata = lat_wdata_q;

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one instance at WAIT_CYCLES=1, one at 3,
// each backed by a small combinational-read memory model.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: WAIT_CYCLES = 1 ----------------
  logic        a_cpu_req, a_cpu_we, a_ldr_req, a_ldr_we, a_ldr_lock;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_ldr_addr, a_ldr_wdata;
  logic [31:0] a_cpu_rdata, a_ldr_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic        a_cpu_ready, a_ldr_ack, a_dm_we, a_busy;
  logic [31:0] mem_a [64] = '{default: 32'h0};
  int          a_wr_cnt = 0, a_rdy_cnt = 0, a_ack_cnt = 0;

  dm_arbiter #(.WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr),
    .ldr_wdata(a_ldr_wdata), .ldr_rdata(a_ldr_rdata), .ldr_ack(a_ldr_ack),
    .ldr_lock(a_ldr_lock),
    .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata), .dm_we(a_dm_we),
    .dm_rdata(a_dm_rdata), .busy(a_busy)
  );

  assign a_dm_rdata = mem_a[a_dm_addr[7:2]];
  always @(posedge clk) begin
    if (a_dm_we) begin
      mem_a[a_dm_addr[7:2]] <= a_dm_wdata;
      a_wr_cnt <= a_wr_cnt + 1;
    end
    if (a_cpu_ready) a_rdy_cnt <= a_rdy_cnt + 1;
    if (a_ldr_ack)   a_ack_cnt <= a_ack_cnt + 1;
  end

  // ---------------- instance B: WAIT_CYCLES = 3 ----------------
  logic        b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we, b_ldr_lock;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_ldr_addr, b_ldr_wdata;
  logic [31:0] b_cpu_rdata, b_ldr_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic        b_cpu_ready, b_ldr_ack, b_dm_we, b_busy;
  logic [31:0] mem_b [64] = '{default: 32'h5A5A_0000};
  int          b_wr_cnt = 0, b_ack_cnt = 0;

  dm_arbiter #(.WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr),
    .ldr_wdata(b_ldr_wdata), .ldr_rdata(b_ldr_rdata), .ldr_ack(b_ldr_ack),
    .ldr_lock(b_ldr_lock),
    .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata), .dm_we(b_dm_we),
    .dm_rdata(b_dm_rdata), .busy(b_busy)
  );

  assign b_dm_rdata = mem_b[b_dm_addr[7:2]];
  always @(posedge clk) begin
    if (b_dm_we) begin
      mem_b[b_dm_addr[7:2]] <= b_dm_wdata;
      b_wr_cnt <= b_wr_cnt + 1;
    end
    if (b_ldr_ack) b_ack_cnt <= b_ack_cnt + 1;
  end

  // Inputs change on the falling edge; outputs are checked on the falling
  // edge before driving, i.e. mid-cycle and away from the sampling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int snap_w, snap_r, snap_a, k;
  bit saw_rdy;

  initial begin
    rst_n = 1'b0;
    {a_cpu_req, a_cpu_we, a_ldr_req, a_ldr_we, a_ldr_lock} = '0;
    {a_cpu_addr, a_cpu_wdata, a_ldr_addr, a_ldr_wdata} = '0;
    {b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we, b_ldr_lock} = '0;
    {b_cpu_addr, b_cpu_wdata, b_ldr_addr, b_ldr_wdata} = '0;

    #1;
    check("rst_cpu_rdata", a_cpu_rdata, 32'h0);
    check("rst_ldr_rdata", a_ldr_rdata, 32'h0);
    check("rst_handshake", {a_cpu_ready, a_ldr_ack, a_dm_we, a_busy}, 4'b0);
    check("rst_dm_bus", {a_dm_addr, a_dm_wdata}, 64'h0);
    do_reset();

    // ---- CPU write 0x10 / DEADBEEF, WAIT_CYCLES=1 ----
    snap_w = a_wr_cnt;
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h10; a_cpu_wdata = 32'hDEAD_BEEF;
    step();                                             // cycle 1
    check("wr_c1_we", a_dm_we, 1'b1);
    check("wr_c1_addr", a_dm_addr, 32'h10);
    check("wr_c1_wdata", a_dm_wdata, 32'hDEAD_BEEF);
    check("wr_c1_ready", {a_cpu_ready, a_ldr_ack, a_busy}, 3'b001);
    step();                                             // cycle 2
    check("wr_c2_ready", {a_cpu_ready, a_ldr_ack, a_dm_we}, 3'b100);
    a_cpu_req = 0;
    step();                                             // cycle 3
    check("wr_c3_idle", {a_cpu_ready, a_busy, a_dm_we}, 3'b000);
    check("wr_count", a_wr_cnt - snap_w, 1);
    check("wr_mem", mem_a[4], 32'hDEAD_BEEF);

    // ---- CPU read-back 0x10 ----
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h10; a_cpu_wdata = 32'h0;
    step();
    check("rd_c1_we", a_dm_we, 1'b0);
    step();
    check("rd_c2_ready", a_cpu_ready, 1'b1);
    check("rd_c2_rdata", a_cpu_rdata, 32'hDEAD_BEEF);
    a_cpu_req = 0;
    step();
    check("rd_count", a_wr_cnt - snap_w, 1);

    // ---- Simultaneous writes from reset: CPU first, loader next ----
    do_reset();
    snap_w = a_wr_cnt;
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h4; a_cpu_wdata = 32'h1111_1111;
    a_ldr_req = 1; a_ldr_we = 1; a_ldr_addr = 32'h8; a_ldr_wdata = 32'h2222_2222;
    step();                                             // cycle 1
    check("sim_c1", {a_dm_we, a_dm_addr}, {1'b1, 32'h4});
    step();                                             // cycle 2
    check("sim_c2", {a_cpu_ready, a_ldr_ack}, 2'b10);
    a_cpu_req = 0;
    step();                                             // cycle 3
    check("sim_c3", {a_cpu_ready, a_ldr_ack, a_busy}, 3'b000);
    step();                                             // cycle 4
    check("sim_c4", {a_dm_we, a_dm_addr, a_dm_wdata}, {1'b1, 32'h8, 32'h2222_2222});
    step();                                             // cycle 5
    check("sim_c5", {a_cpu_ready, a_ldr_ack}, 2'b01);
    a_ldr_req = 0;
    step();
    check("sim_wr_count", a_wr_cnt - snap_w, 2);
    check("sim_mem", {mem_a[1], mem_a[2]}, {32'h1111_1111, 32'h2222_2222});
    step();

    // ---- Lock: 20 cycles with both requesting, only loader served ----
    a_ldr_lock = 1;
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h4;
    a_ldr_req = 1; a_ldr_we = 0; a_ldr_addr = 32'h8;
    snap_r = a_rdy_cnt; snap_a = a_ack_cnt; snap_w = a_wr_cnt;
    saw_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (a_cpu_ready) saw_rdy = 1;
    end
    check("lock_no_cpu_ready", saw_rdy, 1'b0);
    check("lock_rdy_count", a_rdy_cnt - snap_r, 0);
    check("lock_ack_count", a_ack_cnt - snap_a, 6);
    check("lock_ldr_rdata", a_ldr_rdata, 32'h2222_2222);
    check("lock_no_write", a_wr_cnt - snap_w, 0);
    a_ldr_lock = 0;
    a_ldr_req = 0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (a_cpu_ready) begin
        k = i;
        break;
      end
    end
    check("unlock_ready_cycle", k, 3);
    check("unlock_cpu_rdata", a_cpu_rdata, 32'h1111_1111);
    a_cpu_req = 0;
    step();
    step();

    // ---- WAIT_CYCLES=3: loader read 0x20 ----
    snap_a = b_ack_cnt;
    b_ldr_req = 1; b_ldr_we = 0; b_ldr_addr = 32'h20;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("w3_access_c%0d", c),
            {b_dm_addr, b_dm_we, b_ldr_ack, b_busy}, {32'h20, 3'b001});
    end
    step();                                             // cycle 4
    check("w3_ack", {b_ldr_ack, b_cpu_ready}, 2'b10);
    check("w3_ldr_rdata", b_ldr_rdata, 32'h5A5A_0000);
    b_ldr_req = 0;
    step();
    check("w3_ack_low", b_ldr_ack, 1'b0);
    check("w3_ack_count", b_ack_cnt - snap_a, 1);

    // ---- WAIT_CYCLES=3: reset during the 2nd ACCESS cycle of a write ----
    snap_w = b_wr_cnt;
    b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 32'h30; b_cpu_wdata = 32'hCAFE_F00D;
    step();                                             // cycle 1: ACCESS
    check("rst_mid_c1_busy", b_busy, 1'b1);
    step();                                             // cycle 2: ACCESS
    rst_n = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    #1;
    check("rst_mid_async", {b_dm_we, b_busy}, 2'b00);
    step();
    step();
    rst_n = 1;
    step();
    step();
    check("rst_mid_no_write", b_wr_cnt - snap_w, 0);
    check("rst_mid_mem", mem_b[12], 32'h5A5A_0000);
    check("rst_mid_outs", {b_dm_addr, b_dm_wdata, b_cpu_rdata, b_ldr_rdata}, 128'h0);
    check("rst_mid_ctrl", {b_cpu_ready, b_ldr_ack, b_dm_we, b_busy}, 4'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule : tb_dm_arbiter
